// File: rtl/rtc_pkg.sv
// Shared types, seven-segment constants and BCD helpers for the RTC core.

package rtc_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] min;
        logic [7:0] sec;
    } rtc_time_t;

    localparam logic [7:0] MAX_HR = 8'h23;
    localparam logic [7:0] MAX_MS = 8'h59;

    // Active-low patterns, bit 6 = a ... bit 0 = g
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Both nibbles decimal and the packed value within range (BCD orders like binary)
    function automatic logic bcd_valid(input logic [7:0] v, input logic [7:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    // Two-digit BCD increment wrapping to 00 after max
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max) begin
            return 8'h00;
        end
        if (v[3:0] == 4'd9) begin
            return {4'(v[7:4] + 4'd1), 4'd0};
        end
        return v + 8'd1;
    endfunction

endpackage

// File: rtl/rtc_seg7_dec.sv
// BCD digit to seven-segment pattern with blanking and selectable polarity.

module rtc_seg7_dec
    import rtc_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  bcd_t       digit,
    input  logic       blank,
    output logic [6:0] seg_c
);

    logic [6:0] pat;

    always_comb begin
        pat = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    pat = SEG_0;
                4'd1:    pat = SEG_1;
                4'd2:    pat = SEG_2;
                4'd3:    pat = SEG_3;
                4'd4:    pat = SEG_4;
                4'd5:    pat = SEG_5;
                4'd6:    pat = SEG_6;
                4'd7:    pat = SEG_7;
                4'd8:    pat = SEG_8;
                4'd9:    pat = SEG_9;
                default: pat = SEG_BLANK;
            endcase
        end
        seg_c = SEG_ACTIVE_LOW ? pat : ~pat;
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// Real-time clock: 1 Hz prescaler, BCD time of day, validated set, alarm and
// registered six-digit seven-segment display with 12/24-hour presentation.

module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 50_000_000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          ALARM_EN       = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_12h,
    input  logic       set_en,
    input  logic [7:0] set_hr,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic       set_err,
    input  logic       alarm_arm,
    input  logic [7:0] alarm_hr,
    input  logic [7:0] alarm_min,
    output logic       alarm_hit,
    output logic       tick,
    output logic       pm,
    output logic [6:0] hr_m,
    output logic [6:0] hr_l,
    output logic [6:0] min_m,
    output logic [6:0] min_l,
    output logic [6:0] sec_m,
    output logic [6:0] sec_l
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    rtc_time_t        cur;
    rtc_time_t        nxt;
    rtc_time_t        set_val;
    rtc_time_t        disp_src;
    logic             set_ok;
    logic             set_load;
    logic             wrap;
    logic             alarm_c;

    assign set_val  = '{hr: set_hr, min: set_min, sec: set_sec};
    assign set_ok   = bcd_valid(set_hr, MAX_HR) && bcd_valid(set_min, MAX_MS)
                      && bcd_valid(set_sec, MAX_MS);
    assign set_load = set_en && set_ok;
    assign wrap     = (cnt == CNT_LAST);

    // Next time and prescaler; a valid set overrides a coincident tick
    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt + CNT_W'(1);
        if (set_load) begin
            nxt     = set_val;
            cnt_nxt = '0;
        end else if (wrap) begin
            cnt_nxt = '0;
            nxt.sec = bcd_inc(cur.sec, MAX_MS);
            if (cur.sec == MAX_MS) begin
                nxt.min = bcd_inc(cur.min, MAX_MS);
                if (cur.min == MAX_MS) begin
                    nxt.hr = bcd_inc(cur.hr, MAX_HR);
                end
            end
        end
    end

    assign alarm_c = ALARM_EN && alarm_arm && !set_load && wrap
                     && (nxt.hr == alarm_hr) && (nxt.min == alarm_min) && (nxt.sec == 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= '0;
            cnt       <= '0;
            tick      <= 1'b0;
            set_err   <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            cur       <= nxt;
            cnt       <= cnt_nxt;
            tick      <= (cnt_nxt == CNT_LAST);
            set_err   <= set_en && !set_ok;
            alarm_hit <= alarm_c;
        end
    end

    logic [4:0] hr_bin;
    logic [4:0] hr_12;
    bcd_t       hm_d;
    bcd_t       hl_d;
    logic       hm_blank;
    logic       pm_c;

    assign disp_src = rst ? '0 : cur;
    assign hr_bin   = 5'(disp_src.hr[7:4]) * 5'd10 + 5'(disp_src.hr[3:0]);
    assign pm_c     = (disp_src.hr >= 8'h12);

    // 12-hour presentation; reset in 12-hour mode leaves the tens digit dark
    always_comb begin
        hr_12    = hr_bin;
        hm_d     = disp_src.hr[7:4];
        hl_d     = disp_src.hr[3:0];
        hm_blank = 1'b0;
        if (hr_bin == 5'd0) begin
            hr_12 = 5'd12;
        end else if (hr_bin > 5'd12) begin
            hr_12 = hr_bin - 5'd12;
        end
        if (mode_12h) begin
            hm_d     = (hr_12 >= 5'd10) ? 4'd1 : 4'd0;
            hl_d     = (hr_12 >= 5'd10) ? 4'(hr_12 - 5'd10) : 4'(hr_12);
            hm_blank = (hm_d == 4'd0) || rst;
        end
    end

    logic [6:0] hm_c;
    logic [6:0] hl_c;
    logic [6:0] mm_c;
    logic [6:0] ml_c;
    logic [6:0] sm_c;
    logic [6:0] sl_c;

    rtc_seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hr_m (
        .digit(hm_d), .blank(hm_blank), .seg_c(hm_c)
    );
    rtc_seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hr_l (
        .digit(hl_d), .blank(1'b0), .seg_c(hl_c)
    );
    rtc_seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_min_m (
        .digit(disp_src.min[7:4]), .blank(1'b0), .seg_c(mm_c)
    );
    rtc_seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_min_l (
        .digit(disp_src.min[3:0]), .blank(1'b0), .seg_c(ml_c)
    );
    rtc_seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_sec_m (
        .digit(disp_src.sec[7:4]), .blank(1'b0), .seg_c(sm_c)
    );
    rtc_seg7_dec #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_sec_l (
        .digit(disp_src.sec[3:0]), .blank(1'b0), .seg_c(sl_c)
    );

    // Display registers; rst forces the decode source to 00:00:00, giving the reset pattern
    always_ff @(posedge clk) begin
        pm    <= pm_c;
        hr_m  <= hm_c;
        hr_l  <= hl_c;
        min_m <= mm_c;
        min_l <= ml_c;
        sec_m <= sm_c;
        sec_l <= sl_c;
    end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Scoreboard bench: seconds-of-day reference model predicts every cycle's outputs.

module tb_rtc_timekeeper;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_12h = 1'b0;
    logic       set_en = 1'b0;
    logic [7:0] set_hr = '0;
    logic [7:0] set_min = '0;
    logic [7:0] set_sec = '0;
    logic       set_err;
    logic       alarm_arm = 1'b0;
    logic [7:0] alarm_hr = '0;
    logic [7:0] alarm_min = '0;
    logic       alarm_hit;
    logic       tick;
    logic       pm;
    logic [6:0] hr_m, hr_l, min_m, min_l, sec_m, sec_l;

    rtc_timekeeper #(.TICK_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .ALARM_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .mode_12h(mode_12h), .set_en(set_en),
        .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec), .set_err(set_err),
        .alarm_arm(alarm_arm), .alarm_hr(alarm_hr), .alarm_min(alarm_min),
        .alarm_hit(alarm_hit), .tick(tick), .pm(pm),
        .hr_m(hr_m), .hr_l(hr_l), .min_m(min_m), .min_l(min_l),
        .sec_m(sec_m), .sec_l(sec_l)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tick;
        logic       set_err;
        logic       alarm_hit;
        logic       pm;
        logic [6:0] hm, hl, mm, ml, sm, sl;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    int         m_time = 0;
    int         m_cnt  = 0;
    bit         g_mode = 1'b0;
    bit         g_arm  = 1'b0;
    logic [7:0] g_ah   = 8'h07;
    logic [7:0] g_am   = 8'h30;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int bcd_val(input logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9) return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + v % 10);
    endfunction

    // Drive one cycle of inputs and push the outputs expected after that edge
    task automatic step(input bit r, input bit se, input logic [7:0] sh,
                        input logic [7:0] sm, input logic [7:0] ss);
        exp_t e;
        int   src, h, dh, hv, mv, sv;
        @(negedge clk);
        rst = r; set_en = se; set_hr = sh; set_min = sm; set_sec = ss;
        mode_12h = g_mode; alarm_arm = g_arm; alarm_hr = g_ah; alarm_min = g_am;

        src  = r ? 0 : m_time;
        h    = src / 3600;
        e.pm = (h >= 12);
        if (g_mode) begin
            dh   = (h % 12 == 0) ? 12 : h % 12;
            e.hm = (r || dh < 10) ? 7'b1111111 : seg_of(dh / 10);
            e.hl = seg_of(dh % 10);
        end else begin
            e.hm = seg_of(h / 10);
            e.hl = seg_of(h % 10);
        end
        e.mm = seg_of((src / 60 % 60) / 10);
        e.ml = seg_of((src / 60 % 60) % 10);
        e.sm = seg_of((src % 60) / 10);
        e.sl = seg_of((src % 60) % 10);

        e.set_err = 1'b0;
        e.alarm_hit = 1'b0;
        if (r) begin
            m_time = 0;
            m_cnt  = 0;
        end else begin
            hv = bcd_val(sh); mv = bcd_val(sm); sv = bcd_val(ss);
            if (se && (hv < 0 || hv > 23 || mv < 0 || mv > 59 || sv < 0 || sv > 59)) begin
                e.set_err = 1'b1;
                se = 1'b0;
            end
            if (se) begin
                m_time = hv * 3600 + mv * 60 + sv;
                m_cnt  = 0;
            end else if (m_cnt == DIV - 1) begin
                m_time = (m_time + 1) % 86400;
                m_cnt  = 0;
                e.alarm_hit = g_arm && (m_time == bcd_val(g_ah) * 3600 + bcd_val(g_am) * 60);
            end else begin
                m_cnt++;
            end
        end
        e.tick = (m_cnt == DIV - 1);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        step(1'b0, 1'b1, h, m, s);
    endtask

    initial begin : monitor
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                g = '{tick: tick, set_err: set_err, alarm_hit: alarm_hit, pm: pm,
                      hm: hr_m, hl: hr_l, mm: min_m, ml: min_l, sm: sec_m, sl: sec_l};
                checks++;
                if (g === e) begin
                    passed++;
                end else begin
                    $display("FAIL outputs @%0t: got tick=%b err=%b alarm=%b pm=%b seg=%b_%b_%b_%b_%b_%b, expected tick=%b err=%b alarm=%b pm=%b seg=%b_%b_%b_%b_%b_%b",
                             $time, g.tick, g.set_err, g.alarm_hit, g.pm, g.hm, g.hl, g.mm, g.ml, g.sm, g.sl,
                             e.tick, e.set_err, e.alarm_hit, e.pm, e.hm, e.hl, e.mm, e.ml, e.sm, e.sl);
                end
            end
        end
    end

    initial begin : stimulus
        int         pick, a_s, t;
        bit         r;
        logic [7:0] sh, sm, ss;

        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        step(1'b1, 1'b1, 8'h12, 8'h00, 8'h00);
        idle(10);

        set_time(8'h23, 8'h59, 8'h58);
        idle(2 * DIV + 3);

        set_time(8'h1A, 8'h00, 8'h00);
        idle(2);
        set_time(8'h24, 8'h00, 8'h00);
        idle(2);
        set_time(8'h05, 8'h60, 8'h00);
        idle(2);

        g_mode = 1'b1;
        set_time(8'h13, 8'h05, 8'h00);
        idle(3);
        set_time(8'h00, 8'h00, 8'h00);
        idle(3);
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        idle(3);

        g_arm = 1'b1; g_ah = 8'h07; g_am = 8'h30;
        set_time(8'h07, 8'h29, 8'h59);
        idle(DIV + 3);
        set_time(8'h07, 8'h30, 8'h00);
        idle(DIV + 3);

        g_mode = 1'b0;
        for (int i = 0; i < 2 * DIV && m_cnt != DIV - 1; i++) idle(1);
        set_time(8'h10, 8'h00, 8'h00);
        idle(2 * DIV + 2);

        idle(2);
        step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        idle(DIV + 2);

        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) g_mode = ~g_mode;
            if ($urandom_range(0, 39) == 0) g_arm = ~g_arm;
            if ($urandom_range(0, 99) == 0) begin
                g_ah = to_bcd($urandom_range(0, 23));
                g_am = to_bcd($urandom_range(0, 59));
            end
            pick = $urandom_range(0, 29);
            if (pick == 0) begin
                a_s = bcd_val(g_ah) * 3600 + bcd_val(g_am) * 60;
                t   = (a_s - $urandom_range(1, 3) + 86400) % 86400;
                step(r, 1'b1, to_bcd(t / 3600), to_bcd(t / 60 % 60), to_bcd(t % 60));
            end else if (pick < 3 || (m_cnt == DIV - 1 && pick < 8)) begin
                sh = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 23));
                sm = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 59));
                ss = ($urandom_range(0, 3) == 0) ? 8'($urandom) : to_bcd($urandom_range(0, 59));
                step(r, 1'b1, sh, sm, ss);
            end else begin
                step(r, 1'b0, 8'h00, 8'h00, 8'h00);
            end
        end
        idle(3);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
